vend_change_controller: RTL and testbench

Credit-side controller of the vending machine. It accumulates inserted coins into a 4-bit credit and drives the A/B operands of the existing 4-bit A>=B comparator (credit vs. selected price). It consumes the comparator's result to vend or flag insufficient funds. It then returns change, or refunds on cancel, one coin at a time over a valid/ack handshake to the coin dispenser.

---
 rtl/vend_change_controller_pkg.sv | 40 ++++
 rtl/comparator_4bit.sv | 18 +
 rtl/vend_change_controller.sv | 136 +++++++++++++
 tb/tb_vend_change_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_change_controller_pkg.sv
// ============================================================================
// Module  : vend_change_controller_pkg
// Brief   : Shared coin codes, coin values, credit ceiling and FSM states
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vend_change_controller_pkg;

  localparam logic [1:0] COIN_1   = 2'b00;
  localparam logic [1:0] COIN_2   = 2'b01;
  localparam logic [1:0] COIN_5   = 2'b10;
  localparam logic [1:0] COIN_BAD = 2'b11;

  localparam logic [2:0] COIN_1_VAL = 3'd1;
  localparam logic [2:0] COIN_2_VAL = 3'd2;
  localparam logic [2:0] COIN_5_VAL = 3'd5;

  localparam int MAX_CREDIT = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  // Unit value of a coin code; the invalid code is worth nothing.
  function automatic logic [2:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_1:  coin_value = COIN_1_VAL;
      COIN_2:  coin_value = COIN_2_VAL;
      COIN_5:  coin_value = COIN_5_VAL;
      default: coin_value = 3'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/comparator_4bit.sv
// ============================================================================
// Module  : comparator_4bit
// Brief   : Unsigned 4-bit magnitude comparator, a_ge_b = (a >= b)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       a_ge_b
);

  assign a_ge_b = (a >= b);

endmodule

`default_nettype wire

// File: rtl/vend_change_controller.sv
// ============================================================================
// Module  : vend_change_controller
// Brief   : Credit accumulation, vend decision and coin-by-coin change return
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_change_controller
  import vend_change_controller_pkg::*;
#(
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = vend_change_controller_pkg::MAX_CREDIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                sel_valid,
  input  logic [CREDIT_W-1:0] sel_price,
  input  logic                cancel,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                vend,
  output logic                insufficient,
  output logic                change_valid,
  output logic [1:0]          change_code,
  output logic                busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                r_coin_reject;
  logic                r_vend;
  logic                r_insufficient;
  logic                w_reject_nxt;
  logic                w_vend_nxt;
  logic                w_insuf_nxt;

  logic                w_ge;
  logic [CREDIT_W:0]   w_sum;
  logic                w_coin_ok;
  logic [1:0]          w_greedy;
  logic [CREDIT_W-1:0] w_change_val;
  logic [CREDIT_W-1:0] w_change_rem;

  comparator_4bit u_cmp (
    .a      (r_credit),
    .b      (sel_price),
    .a_ge_b (w_ge)
  );

  // One extra bit on the sum so an overflowing coin is caught before it wraps.
  assign w_sum     = {1'b0, r_credit} + (CREDIT_W+1)'(coin_value(coin_code));
  assign w_coin_ok = (coin_code != COIN_BAD) && (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  // Greedy coin depends only on the credit register, so it holds until an ack.
  assign w_greedy = (r_credit >= CREDIT_W'(COIN_5_VAL)) ? COIN_5 :
                    (r_credit >= CREDIT_W'(COIN_2_VAL)) ? COIN_2 : COIN_1;
  assign w_change_val = CREDIT_W'(coin_value(w_greedy));
  assign w_change_rem = r_credit - w_change_val;

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_reject_nxt = 1'b0;
    w_vend_nxt   = 1'b0;
    w_insuf_nxt  = 1'b0;
    case (r_state)
      IDLE, COLLECT: begin
        if (cancel) begin
          w_reject_nxt = coin_valid;
          if (r_state == COLLECT) w_state_nxt = CHANGE;
        end else if (sel_valid) begin
          w_reject_nxt = coin_valid;
          if (w_ge) begin
            w_credit_nxt = r_credit - sel_price;
            w_vend_nxt   = 1'b1;
            w_state_nxt  = VEND;
          end else begin
            w_insuf_nxt = 1'b1;
          end
        end else if (coin_valid) begin
          if (w_coin_ok) begin
            w_credit_nxt = w_sum[CREDIT_W-1:0];
            w_state_nxt  = COLLECT;
          end else begin
            w_reject_nxt = 1'b1;
          end
        end
      end
      VEND: begin
        w_reject_nxt = coin_valid;
        w_state_nxt  = (r_credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        w_reject_nxt = coin_valid;
        if (change_ack) begin
          w_credit_nxt = w_change_rem;
          if (w_change_rem == '0) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_credit       <= '0;
      r_coin_reject  <= 1'b0;
      r_vend         <= 1'b0;
      r_insufficient <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_coin_reject  <= w_reject_nxt;
      r_vend         <= w_vend_nxt;
      r_insufficient <= w_insuf_nxt;
    end
  end

  // Change outputs decode the state register, so reset clears them at once.
  assign change_valid = (r_state == CHANGE);
  assign change_code  = change_valid ? w_greedy : 2'b00;
  assign busy         = (r_state == VEND) || (r_state == CHANGE);
  assign credit       = r_credit;
  assign coin_reject  = r_coin_reject;
  assign vend         = r_vend;
  assign insufficient = r_insufficient;

endmodule

`default_nettype wire

// File: tb/tb_vend_change_controller.sv
// ============================================================================
// Module  : tb_vend_change_controller
// Brief   : Directed self-checking bench for vend_change_controller
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vend_change_controller;
  import vend_change_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_code = 2'b00;
  logic       sel_valid = 1'b0;
  logic [3:0] sel_price = 4'd0;
  logic       cancel = 1'b0;
  logic       change_ack = 1'b0;
  logic [3:0] credit;
  logic       coin_reject;
  logic       vend;
  logic       insufficient;
  logic       change_valid;
  logic [1:0] change_code;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  vend_change_controller #(.CREDIT_W(4), .MAX_CREDIT(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_code    (coin_code),
    .sel_valid    (sel_valid),
    .sel_price    (sel_price),
    .cancel       (cancel),
    .change_ack   (change_ack),
    .credit       (credit),
    .coin_reject  (coin_reject),
    .vend         (vend),
    .insufficient (insufficient),
    .change_valid (change_valid),
    .change_code  (change_code),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_code  = code;
    step();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [3:0] price);
    sel_valid = 1'b1;
    sel_price = price;
    step();
    sel_valid = 1'b0;
  endtask

  // Acks each change coin, checking the greedy choice against expected credit.
  task automatic drain(input string tag, input int start_credit);
    int  rem;
    logic [1:0] exp_code;
    rem = start_credit;
    for (int i = 0; i < 20 && rem > 0; i++) begin
      exp_code = (rem >= 5) ? COIN_5 : (rem >= 2) ? COIN_2 : COIN_1;
      check({tag, "_valid"}, change_valid, 1);
      check({tag, "_code"}, change_code, exp_code);
      change_ack = 1'b1;
      step();
      change_ack = 1'b0;
      rem -= (exp_code == COIN_5) ? 5 : (exp_code == COIN_2) ? 2 : 1;
    end
    check({tag, "_done_valid"}, change_valid, 0);
    check({tag, "_done_credit"}, credit, 0);
    check({tag, "_done_busy"}, busy, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_credit", credit, 0);
    check("rst_change_valid", change_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_vend", vend, 0);
    rst = 1'b0;
    step();

    // 5,5,2 -> 12, price 9 -> vend, change 2 then 1
    insert(COIN_5);
    check("t1_credit5", credit, 5);
    insert(COIN_5);
    insert(COIN_2);
    check("t1_credit12", credit, 12);
    select(4'd9);
    check("t1_vend", vend, 1);
    check("t1_credit3", credit, 3);
    check("t1_busy", busy, 1);
    check("t1_vend_cv", change_valid, 0);
    step();
    check("t1_vend_drop", vend, 0);
    check("t1_cv", change_valid, 1);
    check("t1_code2", change_code, COIN_2);
    step();
    check("t1_code2_hold", change_code, COIN_2);
    check("t1_credit3_hold", credit, 3);
    drain("t1_drain", 3);

    // Insufficient funds, then top up and buy
    insert(COIN_5);
    select(4'd9);
    check("t2_insuf", insufficient, 1);
    check("t2_novend", vend, 0);
    check("t2_credit", credit, 5);
    check("t2_busy", busy, 0);
    step();
    check("t2_insuf_drop", insufficient, 0);
    insert(COIN_5);
    check("t2_credit10", credit, 10);
    select(4'd9);
    check("t2_vend", vend, 1);
    step();
    drain("t2_drain", 1);

    // Overflow and invalid coin rejection
    insert(COIN_5);
    insert(COIN_5);
    insert(COIN_2);
    insert(COIN_5);
    check("t3_reject_ovf", coin_reject, 1);
    check("t3_credit12", credit, 12);
    step();
    check("t3_reject_drop", coin_reject, 0);
    insert(COIN_BAD);
    check("t3_reject_bad", coin_reject, 1);
    check("t3_credit_bad", credit, 12);
    insert(COIN_1);
    check("t3_reject_1ok", coin_reject, 0);
    check("t3_credit13", credit, 13);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    drain("t3_drain", 13);

    // Cancel with simultaneous coin, delayed ack keeps code stable
    insert(COIN_5);
    insert(COIN_2);
    cancel     = 1'b1;
    coin_valid = 1'b1;
    coin_code  = COIN_1;
    step();
    cancel     = 1'b0;
    coin_valid = 1'b0;
    check("t4_reject", coin_reject, 1);
    check("t4_credit7", credit, 7);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_code", change_code, COIN_5);
      check("t4_hold_valid", change_valid, 1);
      step();
    end
    drain("t4_drain", 7);

    // Cancel in IDLE is a no-op
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("t4_idle_cancel_busy", busy, 0);
    check("t4_idle_cancel_cv", change_valid, 0);

    // Exact price: vend, then IDLE with no change; coin in VEND rejected
    insert(COIN_5);
    insert(COIN_2);
    insert(COIN_2);
    check("t5_credit9", credit, 9);
    select(4'd9);
    check("t5_vend", vend, 1);
    check("t5_credit0", credit, 0);
    coin_valid = 1'b1;
    coin_code  = COIN_1;
    step();
    coin_valid = 1'b0;
    check("t5_reject", coin_reject, 1);
    check("t5_cv", change_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_credit", credit, 0);

    // Price 0 in IDLE vends with nothing inserted
    select(4'd0);
    check("t5_price0_vend", vend, 1);
    step();
    check("t5_price0_cv", change_valid, 0);

    // Async reset mid-CHANGE
    insert(COIN_5);
    insert(COIN_2);
    insert(COIN_1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("t6_cv", change_valid, 1);
    check("t6_credit8", credit, 8);
    #2 rst = 1'b1;
    #1;
    check("t6_async_cv", change_valid, 0);
    check("t6_async_code", change_code, 0);
    check("t6_async_credit", credit, 0);
    check("t6_async_busy", busy, 0);
    step();
    rst = 1'b0;
    step();
    check("t6_post_credit", credit, 0);
    check("t6_post_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
